// File: rtl/soc_system_lock_supervisor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_lock_supervisor_pkg
//  Description : Shared constants for the PLL lock supervisor: FSM state
//                encoding, register addresses and register bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_system_lock_supervisor_pkg;

    // FSM state encoding (visible in STATUS[3:2])
    localparam logic [1:0] c_st_unlocked = 2'd0;
    localparam logic [1:0] c_st_qualify  = 2'd1;
    localparam logic [1:0] c_st_holdoff  = 2'd2;
    localparam logic [1:0] c_st_run      = 2'd3;

    // Register word addresses
    localparam logic [2:0] c_addr_status     = 3'd0;
    localparam logic [2:0] c_addr_loss_count = 3'd1;
    localparam logic [2:0] c_addr_control    = 3'd2;
    localparam logic [2:0] c_addr_clear      = 3'd3;

    // STATUS bit positions
    localparam int c_status_locked_s_bit    = 0;
    localparam int c_status_locked_qual_bit = 1;
    localparam int c_status_state_lsb       = 2;
    localparam int c_status_lost_sticky_bit = 4;

    // CONTROL bit positions
    localparam int c_ctrl_irq_en_bit      = 0;
    localparam int c_ctrl_force_reset_bit = 1;

    // CLEAR bit positions
    localparam int c_clr_lost_sticky_bit = 0;
    localparam int c_clr_loss_cnt_bit    = 1;

endpackage
`default_nettype wire

// File: rtl/soc_system_lock_supervisor_if.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_lock_supervisor_if
//  Description : Avalon-MM register bus between the bridge and the lock
//                supervisor (read latency 1, no read strobe needed).
//  Revision    : 1.0 - initial release
// ============================================================================
interface soc_system_lock_supervisor_if;

    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        output readdata
    );

endinterface
`default_nettype wire

// File: rtl/soc_system_lock_sync.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_lock_sync
//  Description : Two-flop synchronizer for the asynchronous PLL locked pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_lock_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_sync1;
    logic r_sync2;

    // Two-stage capture of the asynchronous input; both stages clear on reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

    assign o_sync = r_sync2;

endmodule
`default_nettype wire

// File: rtl/soc_system_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_lock_supervisor
//  Description : Qualifies the PLL locked input, sequences the downstream
//                fabric reset through a hold-off period, counts loss-of-lock
//                events and raises a maskable interrupt. Avalon-MM slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_lock_supervisor
    import soc_system_lock_supervisor_pkg::*;
#(
    parameter int QUAL_CYCLES    = 1024,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_port,
    soc_system_lock_supervisor_if.slave   avs,
    output logic                          irq,
    output logic                          locked_qual,
    output logic                          downstream_reset_n
);

    // One shared counter serves both the qualify and hold-off phases
    localparam int c_cnt_range = (QUAL_CYCLES > HOLDOFF_CYCLES) ? QUAL_CYCLES : HOLDOFF_CYCLES;
    localparam int c_cnt_w     = $clog2(c_cnt_range);

    localparam logic [c_cnt_w-1:0] c_qual_last    = c_cnt_w'(QUAL_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_holdoff_last = c_cnt_w'(HOLDOFF_CYCLES - 1);

    logic               w_locked_s;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_loss;

    logic               r_irq_en;
    logic               r_force_reset;
    logic               r_lost_sticky;
    logic [CNT_W-1:0]   r_loss_cnt;
    logic               r_locked_qual;
    logic               r_downstream_reset_n;
    logic [31:0]        r_readdata;

    logic               w_wr_control;
    logic               w_wr_clear;
    logic               w_irq_en_nxt;
    logic               w_force_reset_nxt;
    logic               w_locked_qual_nxt;
    logic               w_downstream_reset_n_nxt;
    logic [31:0]        w_readdata_nxt;
    logic               w_unused;

    soc_system_lock_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (in_port),
        .o_sync  (w_locked_s)
    );

    // FSM state and phase counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_st_unlocked;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: a drop of locked_s after qualification counts as a loss
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss      = 1'b0;
        case (r_state)
            c_st_unlocked: begin
                if (w_locked_s) begin
                    w_state_nxt = c_st_qualify;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_qualify: begin
                if (!w_locked_s) begin
                    w_state_nxt = c_st_unlocked;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_qual_last) begin
                    w_state_nxt = c_st_holdoff;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_holdoff: begin
                if (!w_locked_s) begin
                    w_state_nxt = c_st_unlocked;
                    w_cnt_nxt   = '0;
                    w_loss      = 1'b1;
                end else if (r_cnt == c_holdoff_last) begin
                    w_state_nxt = c_st_run;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_run: begin
                if (!w_locked_s) begin
                    w_state_nxt = c_st_unlocked;
                    w_cnt_nxt   = '0;
                    w_loss      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_unlocked;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs flip on the same edge as the state
    always_comb begin
        w_locked_qual_nxt        = (w_state_nxt == c_st_holdoff) || (w_state_nxt == c_st_run);
        w_downstream_reset_n_nxt = (w_state_nxt == c_st_run) && !w_force_reset_nxt;
    end

    // Write decode; addresses 4-7 never match so their writes are dropped
    always_comb begin
        w_wr_control      = avs.write && (avs.address == c_addr_control);
        w_wr_clear        = avs.write && (avs.address == c_addr_clear);
        w_irq_en_nxt      = w_wr_control ? avs.writedata[c_ctrl_irq_en_bit]      : r_irq_en;
        w_force_reset_nxt = w_wr_control ? avs.writedata[c_ctrl_force_reset_bit] : r_force_reset;
    end

    // Control, loss bookkeeping and registered outputs; a new loss beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq_en             <= 1'b0;
            r_force_reset        <= 1'b0;
            r_lost_sticky        <= 1'b0;
            r_loss_cnt           <= '0;
            r_locked_qual        <= 1'b0;
            r_downstream_reset_n <= 1'b0;
        end else begin
            r_irq_en             <= w_irq_en_nxt;
            r_force_reset        <= w_force_reset_nxt;
            r_locked_qual        <= w_locked_qual_nxt;
            r_downstream_reset_n <= w_downstream_reset_n_nxt;

            if (w_loss) begin
                r_lost_sticky <= 1'b1;
            end else if (w_wr_clear && avs.writedata[c_clr_lost_sticky_bit]) begin
                r_lost_sticky <= 1'b0;
            end

            if (w_wr_clear && avs.writedata[c_clr_loss_cnt_bit]) begin
                r_loss_cnt <= w_loss ? CNT_W'(1) : '0;
            end else if (w_loss && (r_loss_cnt != {CNT_W{1'b1}})) begin
                r_loss_cnt <= r_loss_cnt + 1'b1;
            end
        end
    end

    // Read mux; unmapped and write-only addresses read as zero
    always_comb begin
        w_readdata_nxt = '0;
        case (avs.address)
            c_addr_status: begin
                w_readdata_nxt[c_status_locked_s_bit]                     = w_locked_s;
                w_readdata_nxt[c_status_locked_qual_bit]                  = r_locked_qual;
                w_readdata_nxt[c_status_state_lsb+1:c_status_state_lsb]   = r_state;
                w_readdata_nxt[c_status_lost_sticky_bit]                  = r_lost_sticky;
            end
            c_addr_loss_count: begin
                w_readdata_nxt = 32'(r_loss_cnt);
            end
            c_addr_control: begin
                w_readdata_nxt[c_ctrl_irq_en_bit]      = r_irq_en;
                w_readdata_nxt[c_ctrl_force_reset_bit] = r_force_reset;
            end
            default: begin
                w_readdata_nxt = '0;
            end
        endcase
    end

    // Read data register, refreshed every cycle from the current address
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_readdata_nxt;
        end
    end

    assign w_unused           = &{1'b0, avs.writedata[31:2]};
    assign avs.readdata       = r_readdata;
    assign irq                = r_irq_en & r_lost_sticky;
    assign locked_qual        = r_locked_qual;
    assign downstream_reset_n = r_downstream_reset_n;

endmodule
`default_nettype wire
